// File: rtl/i2c_lm75_responder.sv
// LM75-style I2C temperature sensor responder.
// Answers at DEV_ADDR and exposes four registers through a 2-bit pointer:
// temperature (snapshotted per read), config (read/write), Thyst and Tos (read-only).
// The SDA output is open-drain: sda_oe=1 pulls the line low.
module i2c_lm75_responder #(
   parameter logic [6:0]  DEV_ADDR = 7'h48,
   parameter logic [15:0] THYST    = 16'h4B00,
   parameter logic [15:0] TOS      = 16'h5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   input  logic [8:0] temp_in,
   output logic [7:0] cfg_out,
   output logic       busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
   } state_t;

   logic scl_meta, scl_sync, scl_prev;
   logic sda_meta, sda_sync, sda_prev;

   state_t     state_reg, state_next;
   logic [3:0] cnt_reg, cnt_next;
   logic [7:0] shift_reg, shift_next;
   logic [7:0] tx_reg, tx_next;
   logic       oe_reg, oe_next;
   logic       busy_reg, busy_next;
   logic [7:0] cfg_reg, cfg_next;
   logic [1:0] ptr_reg, ptr_next;
   logic [8:0] snap_reg, snap_next;
   logic       sel_reg, sel_next;

   logic scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] byte_first, byte_next;

   // Byte served for a given pointer and byte-within-register select.
   function automatic logic [7:0] rd_byte(input logic [1:0] p, input logic s,
                                          input logic [8:0] t, input logic [7:0] c);
      logic [7:0] r;
      case (p)
         2'd0:    r = s ? {t[0], 7'b0} : t[8:1];
         2'd1:    r = c;
         2'd2:    r = s ? THYST[7:0] : THYST[15:8];
         default: r = s ? TOS[7:0] : TOS[15:8];
      endcase
      return r;
   endfunction

   // Synchronize the bus pins and keep their previous-cycle values (idle-high after reset).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_meta <= 1'b1; scl_sync <= 1'b1; scl_prev <= 1'b1;
         sda_meta <= 1'b1; sda_sync <= 1'b1; sda_prev <= 1'b1;
      end else begin
         scl_meta <= scl_i;    scl_sync <= scl_meta; scl_prev <= scl_sync;
         sda_meta <= sda_i;    sda_sync <= sda_meta; sda_prev <= sda_sync;
      end
   end

   // An SDA transition seen with SCL high (even on the SCL rising cycle) is a bus condition.
   assign scl_rise  = scl_sync & ~scl_prev;
   assign scl_fall  = ~scl_sync & scl_prev;
   assign start_det = scl_sync & sda_prev & ~sda_sync;
   assign stop_det  = scl_sync & ~sda_prev & sda_sync;

   assign byte_first = rd_byte(ptr_reg, 1'b0, snap_reg, cfg_reg);
   assign byte_next  = rd_byte(ptr_reg, ~sel_reg, snap_reg, cfg_reg);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;  cnt_reg  <= '0;   shift_reg <= '0;  tx_reg  <= '0;
         oe_reg    <= 1'b0;  busy_reg <= 1'b0; cfg_reg   <= '0;  ptr_reg <= '0;
         snap_reg  <= '0;    sel_reg  <= 1'b0;
      end else begin
         state_reg <= state_next; cnt_reg  <= cnt_next;  shift_reg <= shift_next; tx_reg  <= tx_next;
         oe_reg    <= oe_next;    busy_reg <= busy_next; cfg_reg   <= cfg_next;   ptr_reg <= ptr_next;
         snap_reg  <= snap_next;  sel_reg  <= sel_next;
      end
   end

   // Next-state logic; SDA drive only changes on SCL falling edges, START/STOP override everything.
   always_comb begin
      state_next = state_reg; cnt_next  = cnt_reg;  shift_next = shift_reg; tx_next  = tx_reg;
      oe_next    = oe_reg;    busy_next = busy_reg; cfg_next   = cfg_reg;   ptr_next = ptr_reg;
      snap_next  = snap_reg;  sel_next  = sel_reg;
      case (state_reg)
         ADDR, PTR, WDATA: begin
            if (scl_rise) begin
               shift_next = {shift_reg[6:0], sda_sync};
               cnt_next   = cnt_reg + 4'd1;
            end else if (scl_fall && cnt_reg == 4'd8) begin
               cnt_next = '0;
               if (state_reg == ADDR) begin
                  if (shift_reg[7:1] == DEV_ADDR) begin
                     state_next = ADDR_ACK;
                     oe_next    = 1'b1;
                     busy_next  = 1'b1;
                     if (shift_reg[0]) snap_next = temp_in;
                  end else begin
                     state_next = WAIT_STOP;
                  end
               end else if (state_reg == PTR) begin
                  ptr_next   = shift_reg[1:0];
                  state_next = PTR_ACK;
                  oe_next    = 1'b1;
               end else begin
                  if (ptr_reg == 2'd1) cfg_next = shift_reg;
                  state_next = WDATA_ACK;
                  oe_next    = 1'b1;
               end
            end
         end
         ADDR_ACK: begin
            if (scl_fall) begin
               cnt_next = '0;
               if (shift_reg[0]) begin
                  state_next = RDATA;
                  sel_next   = 1'b0;
                  tx_next    = byte_first;
                  oe_next    = ~byte_first[7];
               end else begin
                  state_next = PTR;
                  oe_next    = 1'b0;
               end
            end
         end
         PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
               state_next = WDATA;
               cnt_next   = '0;
               oe_next    = 1'b0;
            end
         end
         RDATA: begin
            if (scl_fall) begin
               if (cnt_reg == 4'd7) begin
                  state_next = RDATA_ACK;
                  cnt_next   = '0;
                  oe_next    = 1'b0;
               end else begin
                  tx_next  = {tx_reg[6:0], 1'b0};
                  oe_next  = ~tx_reg[6];
                  cnt_next = cnt_reg + 4'd1;
               end
            end
         end
         RDATA_ACK: begin
            if (scl_rise && sda_sync) begin
               state_next = WAIT_STOP;
            end else if (scl_fall) begin
               state_next = RDATA;
               sel_next   = ~sel_reg;
               tx_next    = byte_next;
               oe_next    = ~byte_next[7];
            end
         end
         default: ;
      endcase
      if (stop_det) begin
         state_next = IDLE;
         cnt_next   = '0;
         oe_next    = 1'b0;
         busy_next  = 1'b0;
      end else if (start_det) begin
         state_next = ADDR;
         cnt_next   = '0;
         oe_next    = 1'b0;
         busy_next  = 1'b0;
      end
   end

   assign sda_oe  = oe_reg;
   assign cfg_out = cfg_reg;
   assign busy    = busy_reg;

endmodule

// File: tb/tb_i2c_lm75_responder.sv
// Directed bench for i2c_lm75_responder: an I2C master model drives the bus,
// expected read bytes go into a scoreboard queue and are popped as bytes arrive.
module tb_i2c_lm75_responder;

   localparam int Q = 8;   // clk cycles per quarter SCL bit

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl_i = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_i;
   logic       sda_oe;
   logic [8:0] temp_in = 9'h032;
   logic [7:0] cfg_out;
   logic       busy;

   int n_checks = 0;
   int n_err    = 0;
   int oe_hi_cnt = 0;
   logic [7:0] exp_q[$];

   // Wired-AND open-drain bus.
   assign sda_i = m_sda & ~sda_oe;

   always #20 clk = ~clk;

   // Count cycles where the responder pulls SDA.
   always @(posedge clk) if (sda_oe) oe_hi_cnt <= oe_hi_cnt + 1;

   i2c_lm75_responder dut (
      .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
      .temp_in(temp_in), .cfg_out(cfg_out), .busy(busy)
   );

   task automatic qwait();
      repeat (Q) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic i2c_start();
      qwait(); m_sda = 1'b1;
      qwait(); scl_i = 1'b1;
      qwait(); m_sda = 1'b0;
      qwait(); scl_i = 1'b0;
   endtask

   task automatic i2c_stop();
      qwait(); m_sda = 1'b0;
      qwait(); scl_i = 1'b1;
      qwait(); m_sda = 1'b1;
      qwait();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         qwait(); m_sda = b[i];
         qwait(); scl_i = 1'b1;
         qwait(); qwait(); scl_i = 1'b0;
      end
      qwait(); m_sda = 1'b1;
      qwait(); scl_i = 1'b1;
      qwait(); ack = ~sda_i;
      qwait(); scl_i = 1'b0;
      $display("txn write 0x%02h ack=%0b", b, ack);
   endtask

   task automatic read_byte(input logic ack);
      logic [7:0] b;
      logic [7:0] e;
      m_sda = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         qwait(); scl_i = 1'b1;
         qwait(); b[i] = sda_i;
         qwait(); scl_i = 1'b0;
      end
      m_sda = ack ? 1'b0 : 1'b1;
      qwait(); scl_i = 1'b1;
      qwait(); chk("rd_ack_bit_released", {15'd0, sda_oe}, 16'd0);
      qwait(); scl_i = 1'b0;
      qwait(); m_sda = 1'b1;
      e = exp_q.pop_front();
      chk("rd_byte", {8'd0, b}, {8'd0, e});
      $display("txn read 0x%02h master_ack=%0b", b, ack);
   endtask

   initial begin
      logic a;
      int oe_before;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_cfg", {8'd0, cfg_out}, 16'h0000);
      rst = 1'b1;
      qwait();

      // 25.0 C: set pointer 0, repeated start, read two bytes.
      temp_in = 9'h032;
      i2c_start();
      write_byte(8'h90, a); chk("t31_addr_ack", {15'd0, a}, 16'd1);
      chk("t31_busy", {15'd0, busy}, 16'd1);
      write_byte(8'h00, a); chk("t31_ptr_ack", {15'd0, a}, 16'd1);
      i2c_start();
      write_byte(8'h91, a); chk("t31_raddr_ack", {15'd0, a}, 16'd1);
      exp_q.push_back(8'h19); exp_q.push_back(8'h00);
      read_byte(1'b1);
      read_byte(1'b0);
      chk("t31_released", {15'd0, sda_oe}, 16'd0);
      i2c_stop();
      chk("t31_busy_stop", {15'd0, busy}, 16'd0);

      // -6.5 C with temp changing mid-read; pointer 0 persists.
      temp_in = 9'h1F3;
      i2c_start();
      write_byte(8'h91, a); chk("t32_addr_ack", {15'd0, a}, 16'd1);
      exp_q.push_back(8'hF9); exp_q.push_back(8'h80);
      read_byte(1'b1);
      temp_in = 9'h000;
      read_byte(1'b0);
      i2c_stop();

      // Config write then read pointer 1 three times.
      i2c_start();
      write_byte(8'h90, a); chk("t33_addr_ack", {15'd0, a}, 16'd1);
      write_byte(8'h01, a); chk("t33_ptr_ack", {15'd0, a}, 16'd1);
      write_byte(8'hA5, a); chk("t33_data_ack", {15'd0, a}, 16'd1);
      i2c_stop();
      chk("t33_cfg", {8'd0, cfg_out}, 16'h00A5);
      i2c_start();
      write_byte(8'h91, a); chk("t33_raddr_ack", {15'd0, a}, 16'd1);
      repeat (3) exp_q.push_back(8'hA5);
      read_byte(1'b1);
      read_byte(1'b1);
      read_byte(1'b0);
      i2c_stop();

      // Foreign address must be ignored.
      oe_before = oe_hi_cnt;
      i2c_start();
      write_byte(8'h92, a); chk("t34_no_ack", {15'd0, a}, 16'd0);
      chk("t34_busy", {15'd0, busy}, 16'd0);
      i2c_stop();
      chk("t34_oe_never", oe_hi_cnt - oe_before, 16'd0);
      chk("t34_cfg", {8'd0, cfg_out}, 16'h00A5);

      // Pointer 3 (Tos) wraps, NACK parks in WAIT_STOP which ignores bytes.
      i2c_start();
      write_byte(8'h90, a); chk("t35_addr_ack", {15'd0, a}, 16'd1);
      write_byte(8'h03, a); chk("t35_ptr_ack", {15'd0, a}, 16'd1);
      i2c_start();
      write_byte(8'h91, a); chk("t35_raddr_ack", {15'd0, a}, 16'd1);
      exp_q.push_back(8'h50); exp_q.push_back(8'h00); exp_q.push_back(8'h50);
      read_byte(1'b1);
      read_byte(1'b1);
      read_byte(1'b0);
      chk("t35_busy_wait", {15'd0, busy}, 16'd1);
      write_byte(8'h00, a); chk("t35_wait_ignores", {15'd0, a}, 16'd0);
      i2c_stop();
      chk("t35_busy_idle", {15'd0, busy}, 16'd0);

      // Reset in the middle of the second read byte.
      i2c_start();
      write_byte(8'h91, a); chk("t36_addr_ack", {15'd0, a}, 16'd1);
      exp_q.push_back(8'h50);
      read_byte(1'b1);
      chk("t36_driving", {15'd0, sda_oe}, 16'd1);
      rst = 1'b0;
      #1;
      chk("t36_rst_oe", {15'd0, sda_oe}, 16'd0);
      chk("t36_rst_busy", {15'd0, busy}, 16'd0);
      chk("t36_rst_cfg", {8'd0, cfg_out}, 16'h0000);
      qwait();
      rst = 1'b1;
      qwait();
      i2c_stop();

      // Pointer returned to 0 by reset.
      temp_in = 9'h032;
      i2c_start();
      write_byte(8'h91, a); chk("t36_ptr0_addr_ack", {15'd0, a}, 16'd1);
      exp_q.push_back(8'h19);
      read_byte(1'b0);
      i2c_stop();

      // Full transaction after reset.
      i2c_start();
      write_byte(8'h90, a); chk("t36_w_addr_ack", {15'd0, a}, 16'd1);
      write_byte(8'h01, a); chk("t36_w_ptr_ack", {15'd0, a}, 16'd1);
      write_byte(8'h3C, a); chk("t36_w_data_ack", {15'd0, a}, 16'd1);
      i2c_start();
      write_byte(8'h91, a); chk("t36_r_addr_ack", {15'd0, a}, 16'd1);
      exp_q.push_back(8'h3C);
      read_byte(1'b0);
      i2c_stop();
      chk("t36_cfg", {8'd0, cfg_out}, 16'h003C);
      chk("scoreboard_empty", exp_q.size(), 16'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
